// File: rtl/pbus_cfetch.sv
// P-bus / C-ROM fetch initiator: drives the multiplexed tile address, pulses PCK1B,
// waits out the ROM latency and queues the 32-bit CR word in a 2-entry buffer.
module pbus_cfetch #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned STB_CYC   = 2,
  parameter int unsigned LAT_CYC   = 4
) (
  input  logic        CLK_12M,
  input  logic        nRESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [18:0] REQ_CA,
  input  logic [3:0]  REQ_LN,
  output logic [23:0] PBUS,
  output logic        PCK1B,
  input  logic [31:0] CR,
  output logic        DAT_VALID,
  input  logic        DAT_READY,
  output logic [31:0] DAT,
  output logic        BUSY
);

  localparam logic [3:0] C_SETUP = 4'(SETUP_CYC - 1);
  localparam logic [3:0] C_STB   = 4'(STB_CYC - 1);
  localparam logic [3:0] C_LAT   = 4'(LAT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STB, WAIT} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [23:0] r_pbus;
  logic        r_pck1b;
  logic [31:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  // Ready depends only on state and buffer occupancy, so a slot is always free for the fetch
  assign REQ_READY = (r_state == IDLE) && (r_count < 2'd2);
  assign w_accept  = REQ_VALID && REQ_READY;
  assign w_push    = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_pop     = DAT_VALID && DAT_READY;

  assign PBUS      = r_pbus;
  assign PCK1B     = r_pck1b;
  assign BUSY      = (r_state != IDLE);
  assign DAT_VALID = (r_count != 2'd0);
  assign DAT       = r_mem[r_rd_ptr];

  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_pbus  <= 24'd0;
      r_pck1b <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // Bus layout: [23]=0, [22:20]=CA[23:21], [19:16]=line, [15:0]=CA[20:5]
            r_pbus  <= {1'b0, REQ_CA[18:16], REQ_LN, REQ_CA[15:0]};
            r_cnt   <= C_SETUP;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == 4'd0) begin
            r_pck1b <= 1'b1;
            r_cnt   <= C_STB;
            r_state <= STB;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        STB: begin
          if (r_cnt == 4'd0) begin
            r_pck1b <= 1'b0;
            r_cnt   <= C_LAT;
            r_state <= WAIT;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_pck1b <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count decide what is visible
  always_ff @(posedge CLK_12M) begin
    if (w_push) r_mem[r_wr_ptr] <= CR;
  end

endmodule
